uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

UART boot loader that sits directly upstream of the instruction ROM and data memory programming ports. While the programming request (`upg_rst_i` low) is active it receives an 8N1 byte stream on `rx`, frames it into 32-bit words, and issues one-cycle write strobes with a word address and data. It signals completion to the top level, which then releases the CPU from reset, and it returns a one-byte status on `tx`.

## Interface
- `CLK_FREQ_HZ`, 10_000_000 — frequency of `clock`.
- `BAUD`, 128_000 — line rate. `DIV = CLK_FREQ_HZ/BAUD`, integer-truncated, must be ≥ 8.
- `clock` in 1 — programming clock; all state on rising edge.
- `rst` in 1 — asynchronous, active-low; clears all state.
- `upg_rst_i` in 1 — high: loader held idle, counters cleared, `upg_done_o` cleared; low: loader runs.
- `rx` in 1 — serial input, idle high, asynchronous to `clock`.
- `tx` out 1 — serial output, idle high; reset value 1.
- `upg_wen_o` out 1 — one-cycle write strobe; reset value 0.
- `upg_adr_o` out 15 — `{region, word_index[13:0]}`; reset value 0.
- `upg_dat_o` out 32 — word to write; reset value 0.
- `upg_done_o` out 1 — load complete, sticky; reset value 0.
- `upg_err_o` out 1 — load aborted, sticky; reset value 0.

## Operation
- **rx front end:** 2-flop synchronizer. A falling edge in RX_IDLE starts a frame.
  - Wait `DIV/2` cycles and re-check. If the line is high, it is a false start; return to idle.
  - Sample 8 data bits LSB-first, one every `DIV` cycles, then the stop bit.
  - Stop bit = 0 is a framing error: the byte is dropped, `upg_err_o` is set, and the FSM goes to ACK with status 0x45.
- **Protocol FSM states:** IDLE → HDR_REGION → HDR_CNT_LO → HDR_CNT_HI → DATA → (CHK) → ACK → DONE. It advances on each received byte.
  - HDR_REGION: bit 0 of the byte is `region`, which becomes `upg_adr_o[14]` (0 = instruction ROM, 1 = data memory). Bits 7:1 are ignored.
  - HDR_CNT_LO/HI: 16-bit word count N, little-endian.
  - N = 0 goes directly to ACK (ok).
  - N > 16384 sets `upg_err_o` and goes to ACK with status 0x45.
  - DATA: 4 bytes per word, little-endian (first byte → `[7:0]`). On the 4th byte, `upg_dat_o` and `upg_adr_o` load, and `upg_wen_o` pulses for exactly one cycle.
    - `word_index` starts at 0 and increments after each write. The index 16383 is the last valid value; no wrap can occur because N ≤ 16384.
    - After N words, go to CHK (if configured) or ACK.
  - ACK: transmit one 8N1 byte, 0x4F ok or 0x45 error, at the same `DIV`. Then go to DONE.
  - DONE: `upg_done_o` = 1 (ok path only). Further rx bytes are ignored until `upg_rst_i` rises.
- `upg_rst_i` rising at any point returns the FSM to IDLE.
  - An in-flight tx byte is aborted and `tx` is forced to 1.
  - Words already written stay written.
  - `upg_done_o` and `upg_err_o` clear.
- `upg_adr_o` and `upg_dat_o` hold their last values between strobes.

## Timing
- The byte-valid pulse occurs in the cycle after the stop-bit sample.
- `upg_wen_o` is asserted in the cycle after the 4th byte-valid of a word. Address and data are already stable in that cycle.
- Minimum spacing between strobes is 4 byte times, about 40·`DIV` cycles.
- `upg_done_o` rises the cycle after the ACK stop bit completes (10·`DIV` cycles after entering ACK).
- Asynchronous assertion of `rst` mid-byte clears everything immediately. After release, the FSM waits for a full idle-high line before accepting a start bit.
- Simultaneous `upg_rst_i` rise and byte-valid: `upg_rst_i` wins; the byte is discarded.

## Configuration
- `UART_PROG_LOADER_CHECKSUM_EN` defined:
  - After the N data words, one CHK byte is expected, equal to the XOR of all 4N data bytes.
  - Match: ACK sends 0x4F and `upg_done_o` sets.
  - Mismatch: `upg_err_o` sets and ACK sends 0x45. Words are already written and are not rolled back.
- Not defined: no CHK state; ACK follows the last data byte directly.

## Test plan
- **Normal load:** `DIV`=8, region 0x00, N=2, words 0x12345678 and 0xDEADBEEF.
  - Two `upg_wen_o` pulses: adr 0x0000 with dat 0x12345678, then adr 0x0001 with dat 0xDEADBEEF.
  - `tx` sends 0x4F; `upg_done_o`=1.
- **Data region:** region 0x01, N=1, word 0x000000FF → adr 0x4000, dat 0x000000FF; done=1.
- **Framing error:** stop bit forced 0 on the 3rd data byte.
  - No wen for that word; `upg_err_o`=1; `tx` sends 0x45; done stays 0.
- **Bad count:** N=0x4001 → no wen; `tx`=0x45; err=1. Separately, N=0 → no wen; `tx`=0x4F; done=1.
- **Abort:** `upg_rst_i` raised after 2 of 4 bytes of word 1.
  - No further wen; done=0 and err=0; `tx`=1.
  - A fresh load after dropping `upg_rst_i` starts again at word_index 0.
- **Checksum (macro on):** bytes 01 02 03 04, CHK=0x04 → 0x4F, done=1. Same bytes with CHK=0x05 → one wen still issued, err=1, 0x45.

Source files
------------

// File: rtl/uart_prog_loader_if.sv
// Programming-port bundle driven by the UART boot loader
// toward the instruction ROM / data memory write ports.
interface uart_prog_loader_if;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        upg_err_o;

  modport master (
    output upg_wen_o, upg_adr_o, upg_dat_o,
    output upg_done_o, upg_err_o
  );
  modport slave (
    input upg_wen_o, upg_adr_o, upg_dat_o,
    input upg_done_o, upg_err_o
  );
endinterface

// File: rtl/uart_prog_loader.sv
// UART 8N1 boot loader framing bytes into 32-bit program/data words.
// Define UART_PROG_LOADER_CHECKSUM_EN to require a trailing XOR check byte.
module uart_prog_loader #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD        = 128_000
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               upg_rst_i,
  input  logic               rx,
  output logic               tx,
  uart_prog_loader_if.master upg
);
  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = $clog2(10 * DIV + 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] IDLE_M1 = CW'(10 * DIV - 1);
  localparam logic [15:0] N_MAX  = 16'd16384;
  localparam logic [7:0]  ST_OK  = 8'h4F;
  localparam logic [7:0]  ST_ERR = 8'h45;

  localparam logic [2:0] RX_WAIT  = 3'd0;
  localparam logic [2:0] RX_IDLE  = 3'd1;
  localparam logic [2:0] RX_START = 3'd2;
  localparam logic [2:0] RX_DATA  = 3'd3;
  localparam logic [2:0] RX_STOP  = 3'd4;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_REG  = 3'd1;
  localparam logic [2:0] P_CLO  = 3'd2;
  localparam logic [2:0] P_CHI  = 3'd3;
  localparam logic [2:0] P_DATA = 3'd4;
  localparam logic [2:0] P_ACK  = 3'd5;
  localparam logic [2:0] P_DONE = 3'd6;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] P_CHK  = 3'd7;
`endif

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic [2:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          vld_q, vld_d;
  logic          ferr_q, ferr_d;

  // rx_s3_q is the previous synced level, used for falling-edge detect
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_s3_q  <= 1'b1;
      rx_st_q  <= RX_WAIT;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      vld_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_s1_q  <= rx;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      vld_q    <= vld_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    vld_d    = 1'b0;
    ferr_d   = 1'b0;
    if (upg_rst_i) begin
      rx_st_d  = RX_WAIT;
      rx_cnt_d = '0;
    end else begin
      unique case (rx_st_q)
        RX_WAIT: begin
          if (!rx_s2_q) rx_cnt_d = '0;
          else if (rx_cnt_q == IDLE_M1) rx_st_d = RX_IDLE;
        end
        RX_IDLE: begin
          rx_cnt_d = '0;
          if (!rx_s2_q && rx_s3_q) rx_st_d = RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_M1) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == DIV_M1) begin
            rx_cnt_d = '0;
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == DIV_M1) begin
            rx_st_d = RX_IDLE;
            vld_d   = rx_s2_q;
            ferr_d  = !rx_s2_q;
          end
        end
        default: rx_st_d = RX_WAIT;
      endcase
    end
  end

  logic [2:0]    st_q, st_d;
  logic          region_q, region_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [23:0]   acc_q, acc_d;
  logic          wen_q, wen_d;
  logic [14:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_q, tx_d;
  logic [7:0]    chk_q, chk_d;
  logic          to_ack, set_err, rcv;
  logic [15:0]   n_rx, frame;

  assign n_rx = {rx_sh_q, n_q[7:0]};
  assign rcv  = !(st_q inside {P_IDLE, P_ACK, P_DONE});

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      st_q     <= P_IDLE;
      region_q <= 1'b0;
      n_q      <= '0;
      wcnt_q   <= '0;
      bidx_q   <= '0;
      acc_q    <= '0;
      wen_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_q     <= 1'b1;
      chk_q    <= '0;
    end else begin
      st_q     <= st_d;
      region_q <= region_d;
      n_q      <= n_d;
      wcnt_q   <= wcnt_d;
      bidx_q   <= bidx_d;
      acc_q    <= acc_d;
      wen_q    <= wen_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_q     <= tx_d;
      chk_q    <= chk_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    region_d = region_q;
    n_d      = n_q;
    wcnt_d   = wcnt_q;
    bidx_d   = bidx_q;
    acc_d    = acc_q;
    wen_d    = 1'b0;
    adr_d    = adr_q;
    dat_d    = dat_q;
    done_d   = done_q;
    err_d    = err_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    chk_d    = chk_q;
    to_ack   = 1'b0;
    set_err  = 1'b0;
    if (upg_rst_i) begin
      st_d   = P_IDLE;
      wcnt_d = '0;
      bidx_d = '0;
      done_d = 1'b0;
      err_d  = 1'b0;
      chk_d  = '0;
    end else begin
      unique case (st_q)
        P_IDLE: st_d = P_REG;
        P_REG: begin
          if (vld_q) begin
            region_d = rx_sh_q[0];
            st_d     = P_CLO;
          end
        end
        P_CLO: begin
          if (vld_q) begin
            n_d[7:0] = rx_sh_q;
            st_d     = P_CHI;
          end
        end
        P_CHI: begin
          if (vld_q) begin
            n_d = n_rx;
            if (n_rx == 16'd0) begin
              to_ack = 1'b1;
            end else if (n_rx > N_MAX) begin
              set_err = 1'b1;
              to_ack  = 1'b1;
            end else begin
              st_d = P_DATA;
            end
          end
        end
        P_DATA: begin
          if (vld_q) begin
            bidx_d = bidx_q + 2'd1;
            acc_d  = {rx_sh_q, acc_q[23:8]};
            chk_d  = chk_q ^ rx_sh_q;
            if (bidx_q == 2'd3) begin
              wen_d  = 1'b1;
              dat_d  = {rx_sh_q, acc_q};
              adr_d  = {region_q, wcnt_q[13:0]};
              wcnt_d = wcnt_q + 16'd1;
              if (wcnt_d == n_q) begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                st_d = P_CHK;
`else
                to_ack = 1'b1;
`endif
              end
            end
          end
        end
`ifdef UART_PROG_LOADER_CHECKSUM_EN
        P_CHK: begin
          if (vld_q) begin
            set_err = (rx_sh_q != chk_q);
            to_ack  = 1'b1;
          end
        end
`endif
        P_ACK: begin
          tx_cnt_d = tx_cnt_q + 1'b1;
          if (tx_cnt_q == DIV_M1) begin
            tx_cnt_d = '0;
            tx_bit_d = tx_bit_q + 4'd1;
            if (tx_bit_q == 4'd9) begin
              st_d   = P_DONE;
              done_d = !err_q;
            end
          end
        end
        P_DONE: st_d = P_DONE;
        default: st_d = P_IDLE;
      endcase
      if (ferr_q && rcv) begin
        set_err = 1'b1;
        to_ack  = 1'b1;
      end
      if (set_err) err_d = 1'b1;
      if (to_ack) begin
        st_d     = P_ACK;
        tx_cnt_d = '0;
        tx_bit_d = '0;
      end
    end
  end

  // status frame: start bit, status LSB-first, stop bit, padded high
  assign frame = {6'h3F, 1'b1, err_d ? ST_ERR : ST_OK, 1'b0};
  assign tx_d  = (st_d == P_ACK) ? frame[tx_bit_d] : 1'b1;

  assign tx             = tx_q;
  assign upg.upg_wen_o  = wen_q;
  assign upg.upg_adr_o  = adr_q;
  assign upg.upg_dat_o  = dat_q;
  assign upg.upg_done_o = done_q;
  assign upg.upg_err_o  = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: byte-stream model vs DUT write strobes and status.
// Builds with or without UART_PROG_LOADER_CHECKSUM_EN.
module tb_uart_prog_loader;
  localparam int DIV = 8;

  logic clock = 1'b0;
  logic rst = 1'b0;
  logic upg_rst_i = 1'b1;
  logic rx = 1'b1;
  logic tx;

  uart_prog_loader_if upg ();

  uart_prog_loader #(
    .CLK_FREQ_HZ(1_024_000),
    .BAUD(128_000)
  ) dut (
    .clock(clock),
    .rst(rst),
    .upg_rst_i(upg_rst_i),
    .rx(rx),
    .tx(tx),
    .upg(upg)
  );

  always #5 clock = ~clock;

  int chks = 0;
  int errs = 0;
  logic [46:0] exp_wq[$];
  logic [7:0]  txq[$];
  logic [7:0]  stream[$];
  logic [7:0]  xs;
  logic        wen_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write-port compare against the expected write queue
  always @(negedge clock) begin
    if (rst) begin
      if (upg.upg_wen_o) begin
        check("wen_single_cycle", {31'd0, wen_prev}, 32'd0);
        if (exp_wq.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL unexpected_wen: adr %h dat %h, none expected",
                   upg.upg_adr_o, upg.upg_dat_o);
        end else begin
          logic [46:0] e;
          e = exp_wq.pop_front();
          check("wen_adr", {17'd0, upg.upg_adr_o}, {17'd0, e[46:32]});
          check("wen_dat", upg.upg_dat_o, e[31:0]);
        end
      end
      wen_prev = upg.upg_wen_o;
    end
  end

  // Serial decoder for the status byte on tx
  initial forever begin
    @(negedge clock);
    if (rst && tx === 1'b0) begin
      logic [7:0] b;
      repeat (DIV / 2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clock);
        b[i] = tx;
      end
      repeat (DIV) @(negedge clock);
      check("tx_stop_bit", {31'd0, tx}, 32'd1);
      txq.push_back(b);
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clock);
    end
    rx = stop_ok;
    repeat (DIV) @(negedge clock);
    rx = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic hdr(input logic [7:0] r, input logic [15:0] n);
    stream = {};
    xs = 8'h00;
    stream.push_back(r);
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
  endtask

  task automatic word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) begin
      stream.push_back(w[8*j +: 8]);
      xs = xs ^ w[8*j +: 8];
    end
  endtask

  task automatic tail(input logic [7:0] d);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    stream.push_back(xs ^ d);
`else
    xs = xs ^ d;
`endif
  endtask

  task automatic expect_tx(input logic [7:0] exp);
    int t;
    t = 0;
    while (txq.size() == 0 && t < 40 * DIV) begin
      @(negedge clock);
      t++;
    end
    if (txq.size() == 0) begin
      chks++;
      errs++;
      $display("FAIL tx_timeout: got no status byte, expected %h", exp);
    end else begin
      check("tx_status", {24'd0, txq.pop_front()}, {24'd0, exp});
    end
  endtask

  task automatic release_loader();
    upg_rst_i = 1'b1;
    repeat (4) @(negedge clock);
    check("done_clear", {31'd0, upg.upg_done_o}, 32'd0);
    check("err_clear", {31'd0, upg.upg_err_o}, 32'd0);
    check("tx_idle", {31'd0, tx}, 32'd1);
    upg_rst_i = 1'b0;
    repeat (12 * DIV + 4) @(negedge clock);
  endtask

  task automatic do_load(input int bad, input logic [7:0] exp_st);
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], i != bad);
      if (i == bad) break;
    end
    expect_tx(exp_st);
    repeat (3 * DIV) @(negedge clock);
    check("done", {31'd0, upg.upg_done_o}, {31'd0, exp_st == 8'h4F});
    check("err", {31'd0, upg.upg_err_o}, {31'd0, exp_st != 8'h4F});
    check("writes_left", exp_wq.size(), 32'd0);
    release_loader();
  endtask

  // Random load; expectations follow from the byte-stream rules alone
  task automatic random_load();
    logic        r;
    logic [15:0] n;
    logic [7:0]  cd;
    logic [7:0]  st;
    logic [31:0] wl[$];
    int          sel, bad;
    r   = 1'($urandom);
    sel = $urandom_range(0, 9);
    if (sel == 0) n = 16'd0;
    else if (sel == 1) n = 16'($urandom_range(16385, 65535));
    else n = 16'($urandom_range(1, 3));
    hdr({7'($urandom), r}, n);
    wl = {};
    cd = 8'h00;
    if (n >= 16'd1 && n <= 16'd16384) begin
      for (int k = 0; k < int'(n); k++) begin
        wl.push_back($urandom);
        word(wl[k]);
      end
      if ($urandom_range(0, 3) == 0) cd = 8'($urandom_range(1, 255));
      tail(cd);
    end
    bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, stream.size() - 1) : -1;
    for (int k = 0; k < wl.size(); k++) begin
      if (bad < 0 || bad > 3 + 4 * k + 3)
        exp_wq.push_back({r, 14'(k), wl[k]});
    end
    st = 8'h4F;
    if (bad >= 0 || n > 16'd16384) st = 8'h45;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    if (wl.size() > 0 && cd != 8'h00) st = 8'h45;
`endif
    do_load(bad, st);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_wen", {31'd0, upg.upg_wen_o}, 32'd0);
    check("rst_adr", {17'd0, upg.upg_adr_o}, 32'd0);
    check("rst_dat", upg.upg_dat_o, 32'd0);
    check("rst_done", {31'd0, upg.upg_done_o}, 32'd0);
    check("rst_err", {31'd0, upg.upg_err_o}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clock);
    upg_rst_i = 1'b0;
    repeat (12 * DIV + 4) @(negedge clock);

    hdr(8'h00, 16'd2);
    word(32'h12345678);
    word(32'hDEADBEEF);
    tail(8'h00);
    exp_wq.push_back({15'h0000, 32'h12345678});
    exp_wq.push_back({15'h0001, 32'hDEADBEEF});
    do_load(-1, 8'h4F);

    hdr(8'h01, 16'd1);
    word(32'h000000FF);
    tail(8'h00);
    exp_wq.push_back({15'h4000, 32'h000000FF});
    do_load(-1, 8'h4F);
    check("adr_hold", {17'd0, upg.upg_adr_o}, 32'h4000);
    check("dat_hold", upg.upg_dat_o, 32'h000000FF);

    hdr(8'h00, 16'd2);
    word(32'h11223344);
    word(32'h55667788);
    tail(8'h00);
    do_load(5, 8'h45);

    hdr(8'h00, 16'h4001);
    do_load(-1, 8'h45);
    hdr(8'h00, 16'h0000);
    do_load(-1, 8'h4F);

    hdr(8'h00, 16'd2);
    word(32'hA1B2C3D4);
    word(32'h0BADF00D);
    exp_wq.push_back({15'h0000, 32'hA1B2C3D4});
    for (int i = 0; i < 9; i++) send_byte(stream[i], 1'b1);
    repeat (2 * DIV) @(negedge clock);
    upg_rst_i = 1'b1;
    repeat (4) @(negedge clock);
    check("abort_done", {31'd0, upg.upg_done_o}, 32'd0);
    check("abort_err", {31'd0, upg.upg_err_o}, 32'd0);
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_writes_left", exp_wq.size(), 32'd0);
    repeat (40 * DIV) @(negedge clock);
    check("abort_no_status", txq.size(), 32'd0);
    upg_rst_i = 1'b0;
    repeat (12 * DIV + 4) @(negedge clock);
    hdr(8'h00, 16'd1);
    word(32'hCAFEF00D);
    tail(8'h00);
    exp_wq.push_back({15'h0000, 32'hCAFEF00D});
    do_load(-1, 8'h4F);

    rx = 1'b0;
    repeat (3 * DIV) @(negedge clock);
    rst = 1'b0;
    #1;
    check("arst_adr", {17'd0, upg.upg_adr_o}, 32'd0);
    check("arst_dat", upg.upg_dat_o, 32'd0);
    check("arst_tx", {31'd0, tx}, 32'd1);
    check("arst_done", {31'd0, upg.upg_done_o}, 32'd0);
    rx = 1'b1;
    repeat (4) @(negedge clock);
    rst = 1'b1;
    repeat (12 * DIV + 4) @(negedge clock);
    hdr(8'h00, 16'd1);
    word(32'h5A5AA5A5);
    tail(8'h00);
    exp_wq.push_back({15'h0000, 32'h5A5AA5A5});
    do_load(-1, 8'h4F);

`ifdef UART_PROG_LOADER_CHECKSUM_EN
    stream = {8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    exp_wq.push_back({15'h0000, 32'h04030201});
    do_load(-1, 8'h4F);
    stream = {8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    exp_wq.push_back({15'h0000, 32'h04030201});
    do_load(-1, 8'h45);
`endif

    for (int it = 0; it < 14; it++) random_load();

    $display("Simulation finished: %0d checks, %0d errors", chks, errs);
    $finish;
  end
endmodule
